// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared state type and width helpers for the keypad scanner
// Build option: KEY_RELEASE_EVT_EN widens event codes by one bit for a release flag.
package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SCAN,
        PUSH,
        HOLD
    } kbd_state_e;

    // Bits needed to number every key of a rows x cols matrix.
    function automatic int kbd_kw(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    // Width of one FIFO event: key index, plus the release flag when enabled.
    function automatic int kbd_cw(input int rows, input int cols);
`ifdef KEY_RELEASE_EVT_EN
        return kbd_kw(rows, cols) + 1;
`else
        return kbd_kw(rows, cols);
`endif
    endfunction

    // The release flag sits directly above the key index.
    function automatic int kbd_rel_bit(input int rows, input int cols);
        return kbd_kw(rows, cols);
    endfunction

endpackage

// File: rtl/matrix_key_scanner_if.sv
// rtl/matrix_key_scanner_if.sv - key-event FIFO read port between scanner and CPU side
// Signals: rd_en (pop request), key_valid (FIFO non-empty), key_code (FIFO head),
//          key_overflow (sticky dropped-event flag).
// master: the consumer that pops events; slave: the scanner that owns the FIFO.
interface matrix_key_scanner_if #(
    parameter int CW = 5
);
    logic          rd_en;
    logic          key_valid;
    logic [CW-1:0] key_code;
    logic          key_overflow;

    modport master (output rd_en, input key_valid, input key_code, input key_overflow);
    modport slave  (input rd_en, output key_valid, output key_code, output key_overflow);
endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one asynchronous input: 2-flop synchroniser plus tick-counted debounce
// Ports: clk, RSTN (sync, active-low), tick (scan tick pulse), din (raw input),
//        dout (debounced value).
module debounce_bit
    import kbd_pkg::*;
#(
    parameter int DEB_TICKS = 250000
) (
    input  logic clk,
    input  logic RSTN,
    input  logic tick,
    input  logic din,
    output logic dout
);
    localparam int CNTW = $clog2(DEB_TICKS + 1);

    logic            s1;
    logic            s2;
    logic [CNTW-1:0] cnt;

    // A single bit can only differ from dout in one way, so any return to
    // dout is the "change" that restarts the stability count.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNTW'(DEB_TICKS - 1)) begin
                    dout <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CNTW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/matrix_key_scanner.sv
// rtl/matrix_key_scanner.sv - row/column keypad scanner with debounce, event FIFO and switch debounce
// Ports: clk, RSTN (sync, active-low), key_col_n (column sense, active-low, async),
//        key_row_n (row drive, active-low), sw (raw switches), sw_ok (debounced switches),
//        kbd (event FIFO read port: rd_en / key_valid / key_code / key_overflow).
// Build option: KEY_RELEASE_EVT_EN adds a release event {1, code} when a key is let go.
module matrix_key_scanner
    import kbd_pkg::*;
#(
    parameter int ROWS         = 5,
    parameter int COLS         = 5,
    parameter int NSW          = 16,
    parameter int CLK_DIV      = 8,
    parameter int DEB_TICKS    = 250000,
    parameter int SETTLE_TICKS = 125000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                RSTN,
    input  logic [COLS-1:0]     key_col_n,
    output logic [ROWS-1:0]     key_row_n,
    input  logic [NSW-1:0]      sw,
    output logic [NSW-1:0]      sw_ok,
    matrix_key_scanner_if.slave kbd
);
    localparam int KW   = kbd_kw(ROWS, COLS);
    localparam int CW   = kbd_cw(ROWS, COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int DIVW = $clog2(CLK_DIV);
    localparam int TMAX = (DEB_TICKS > SETTLE_TICKS) ? DEB_TICKS : SETTLE_TICKS;
    localparam int CNTW = $clog2(TMAX + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);

    // ---------------- tick prescaler ----------------
    logic [DIVW-1:0] div_cnt;
    logic            tick;

    assign tick = (div_cnt == DIVW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!RSTN)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIVW'(1);
    end

    // ---------------- column synchroniser ----------------
    logic [COLS-1:0] col_s1;
    logic [COLS-1:0] col_s2;
    logic [COLS-1:0] col;

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            col_s1 <= '1;
            col_s2 <= '1;
        end else begin
            col_s1 <= key_col_n;
            col_s2 <= col_s1;
        end
    end

    assign col = ~col_s2;

    // ---------------- scan FSM ----------------
    kbd_state_e      state;
    kbd_state_e      state_nx;
    logic [COLS-1:0] latch_col;
    logic [CNTW-1:0] cnt;
    logic [RW-1:0]   row;
    logic [KW-1:0]   code_r;
    logic [KW-1:0]   low_idx;
    logic            deb_done;
    logic            set_done;
    logic            last_row;

    assign deb_done = (cnt == CNTW'(DEB_TICKS - 1));
    assign set_done = (cnt == CNTW'(SETTLE_TICKS - 1));
    assign last_row = (row == RW'(ROWS - 1));

    // Lowest set column wins when several keys share the scanned row.
    always_comb begin
        low_idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (col[i]) low_idx = KW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (tick && col != '0) state_nx = DEBOUNCE;
            DEBOUNCE: if (tick) begin
                          if (col == '0)                          state_nx = IDLE;
                          else if (col == latch_col && deb_done) state_nx = SCAN;
                      end
            SCAN:     if (tick && set_done) begin
                          if (col != '0)    state_nx = PUSH;
                          else if (last_row) state_nx = IDLE;
                      end
            PUSH:     state_nx = HOLD;
            HOLD:     if (tick && col == '0 && deb_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Counters and captured values that follow the state transitions.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            latch_col <= '0;
            cnt       <= '0;
            row       <= '0;
            code_r    <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    latch_col <= col;
                    cnt       <= '0;
                end
                DEBOUNCE: begin
                    if (col != latch_col) begin
                        latch_col <= col;
                        cnt       <= '0;
                    end else if (deb_done) begin
                        cnt <= '0;
                        row <= '0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                SCAN: begin
                    if (set_done) begin
                        cnt <= '0;
                        if (col != '0)     code_r <= KW'(row) * KW'(COLS) + low_idx;
                        else if (!last_row) row   <= row + RW'(1);
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                HOLD: begin
                    if (col != '0 || deb_done) cnt <= '0;
                    else                       cnt <= cnt + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    logic          push_req;
    logic [CW-1:0] push_data;

    always_comb begin
        key_row_n = '0;
        push_req  = 1'b0;
        push_data = '0;
        if (state == SCAN) key_row_n = ~(ROWS'(1) << row);
        if (state == PUSH) begin
            push_req  = 1'b1;
            push_data = CW'(code_r);
        end
`ifdef KEY_RELEASE_EVT_EN
        if (state == HOLD && state_nx == IDLE) begin
            push_req  = 1'b1;
            push_data = CW'(code_r);
            push_data[kbd_rel_bit(ROWS, COLS)] = 1'b1;
        end
`endif
    end

    // ---------------- key-event FIFO (show-ahead) ----------------
    logic [CW-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [FCW-1:0] count;
    logic           full;
    logic           pop;
    logic           wr;
    logic           overflow;

    assign full = (count == FCW'(FIFO_DEPTH));
    assign pop  = kbd.rd_en && (count != '0);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign wr   = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({wr, pop})
                2'b10:   count <= count + FCW'(1);
                2'b01:   count <= count - FCW'(1);
                default: ;
            endcase
            if (pop)                   overflow <= 1'b0;
            else if (push_req && full) overflow <= 1'b1;
        end
    end

    assign kbd.key_valid    = (count != '0);
    assign kbd.key_code     = (count != '0) ? mem[rd_ptr] : '0;
    assign kbd.key_overflow = overflow;

    // ---------------- slide switches ----------------
    for (genvar i = 0; i < NSW; i++) begin : g_sw
        debounce_bit #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk  (clk),
            .RSTN (RSTN),
            .tick (tick),
            .din  (sw[i]),
            .dout (sw_ok[i])
        );
    end
endmodule

// File: doc/matrix_key_scanner.md
Name: matrix_key_scanner

Overview:
- Parametrised row/column keypad scanner with tick-based debounce and a key-event FIFO for the CPU, plus per-bit debounced switch inputs.
- Sits between board I/O pins and the peripheral bus/IO controller.
- Generalises the earlier fixed 5x5 scanner: ROWS/COLS, timing and switch count are parameters.
- Adds buffered events with an explicit pop handshake, overflow reporting, and glitch-scan abort.

Parameters:
ROWS, 5, number of driven row lines (>=2)
COLS, 5, number of sensed column lines (>=1)
NSW, 16, number of slide switches
CLK_DIV, 8, clk cycles per scan tick (>=2)
DEB_TICKS, 250000, ticks a pattern must be stable to count as debounced
SETTLE_TICKS, 125000, ticks each row is held before its columns are sampled
FIFO_DEPTH, 4, key-event FIFO entries (power of 2)

Ports:
clk  in  1  system clock
RSTN  in  1  reset, synchronous, active-low
key_col_n  in  COLS  column sense lines, active-low, asynchronous
key_row_n  out  ROWS  row drive lines, active-low
sw  in  NSW  raw switches, asynchronous
rd_en  in  1  pop head of FIFO; honoured only when key_valid=1
key_valid  out  1  FIFO non-empty
key_code  out  CW  FIFO head. CW=KW, where KW=$clog2(ROWS*COLS); CW=KW+1 with the optional feature
key_overflow  out  1  sticky: a key event was dropped because the FIFO was full
sw_ok  out  NSW  debounced switches

Behaviour:
- Inputs: key_col_n and sw each pass through a 2-flop synchroniser. Internal col = ~synced key_col_n.
- Tick: free-running prescaler, 1-clk pulse every CLK_DIV cycles. All FSM and debounce timing advances on ticks only.
- Reset values: key_row_n=0, key_valid=0, key_code=0, key_overflow=0, sw_ok=0. FIFO empty, FSM=IDLE, all counters 0.
- Reset asserted mid-operation aborts everything and discards FIFO contents.
- IDLE: all rows low. Any col bit set -> DEBOUNCE, latch col, cnt=0.
- DEBOUNCE:
  - col differs from latched value -> re-latch, cnt=0.
  - col==0 -> IDLE.
  - cnt reaches DEB_TICKS-1 with a stable nonzero pattern -> SCAN with r=0.
- SCAN(r):
  - key_row_n = ~(1<<r).
  - After SETTLE_TICKS ticks, sample col.
  - Nonzero -> code = r*COLS + index of lowest set col bit, go to PUSH.
  - Zero and r<ROWS-1 -> r+1.
  - Zero and r==ROWS-1 -> IDLE. This is a glitch; no event is generated.
- PUSH: one clk.
  - Write code if the FIFO is not full.
  - If full, drop the code and set key_overflow.
  - Then go to HOLD.
- HOLD: all rows low. Wait for col==0 stable for DEB_TICKS ticks (any nonzero restarts the count) -> IDLE. One event per press; a second key pressed while holding is ignored.
- FIFO (show-ahead):
  - key_code = head whenever key_valid=1; otherwise key_code=0.
  - rd_en with key_valid pops at the clk edge. rd_en while empty is ignored.
  - Push and pop on the same clk while full: both occur, no overflow.
  - Push while empty: key_valid rises the next clk.
- key_overflow clears on the first successful pop after it was set.
- Switches: each bit has an independent counter. sw_ok[i] updates to the synced value after it has been stable DEB_TICKS ticks; any change restarts that bit's count.
- Widths: code arithmetic is done in KW bits; ROWS*COLS-1 always fits.

Optional Feature:
- Macro: KEY_RELEASE_EVT_EN.
- Defined:
  - CW=KW+1. Press events have MSB=0.
  - On HOLD->IDLE, a release event {1'b1, same code} is pushed with the same full/overflow rules.
- Undefined:
  - CW=KW. Press events only; no release logic is present.

Decomposition:
- Package kbd_pkg:
  - state enum (IDLE, DEBOUNCE, SCAN, PUSH, HOLD).
  - KW/CW width functions.
  - Release-flag bit position constant.
- Sub-module debounce_bit (sync + tick counter, parameter DEB_TICKS), instantiated NSW times via generate.
- FIFO stays inline (small).

Test Plan:
Common setup for all tests: ROWS=5, COLS=5, CLK_DIV=2, DEB_TICKS=4, SETTLE_TICKS=2, FIFO_DEPTH=4.
1. Press row 2/col 3; keypad model pulls col low only while row 2 is driven -> exactly one event, key_code=13, key_valid=1. Pulse rd_en -> key_valid=0.
2. Column bounce toggling every tick for 10 ticks, then stable -> exactly one event, emitted only after 4 stable ticks. A 2-tick glitch alone -> no event.
3. Press codes 0,6,12,18,24 without reading -> FIFO holds 0,6,12,18 and key_overflow=1. One pop -> key_code=6, key_overflow=0.
4. FIFO full with a push coinciding with rd_en -> count stays 4, no overflow, new code becomes the tail.
5. sw=16'hA5A5 with bit 0 bouncing 3 ticks -> sw_ok=16'hA5A5 exactly 4 stable ticks later. Reset mid-SCAN -> key_row_n=0, FIFO empty, sw_ok=0.
6. With KEY_RELEASE_EVT_EN defined: press and release key 7 -> events 6'b000111, then 6'b100111.
